// File: rtl/ycr1_dmem_copy.sv
// Word-by-word dmem copy engine: read into a one-word buffer, write it out, repeat; every dmem request is held until acked.
// Optional fill mode (YCR1_DMEM_COPY_FILL_EN) writes cfg_pattern to len words, skipping the reads.
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

module ycr1_dmem_copy #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [31:0]                  cfg_src,
    input  logic [31:0]                  cfg_dst,
    input  logic [LEN_WIDTH-1:0]         cfg_len,
`ifdef YCR1_DMEM_COPY_FILL_EN
    input  logic                         cfg_fill,
    input  logic [31:0]                  cfg_pattern,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [LEN_WIDTH-1:0]         xfer_cnt,
    output logic                         dmem_req,
    output logic                         dmem_cmd,
    output logic [1:0]                   dmem_width,
    output logic [`YCR1_DMEM_AWIDTH-1:0] dmem_addr,
    output logic [`YCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    input  logic                         dmem_req_ack,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    input  logic [1:0]                   dmem_resp
);

    localparam logic       CMD_RD      = 1'b0;
    localparam logic       CMD_WR      = 1'b1;
    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_RDY_OK = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_RSP,
        S_WR_REQ,
        S_WR_RSP,
        S_FIN
    } state_t;

    state_t                r_state;
    logic [31:0]           r_src;
    logic [31:0]           r_dst;
    logic [LEN_WIDTH-1:0]  r_rem;

    logic                  w_rsp_vld;
    logic                  w_rsp_ok;
    logic                  w_rd_end;
    logic                  w_wr_end;
    logic                  w_last;
    logic [31:0]           w_src_nxt;
    logic [31:0]           w_dst_nxt;
    logic                  w_fill;
    logic                  w_start_fill;
    logic [31:0]           w_pattern;

`ifdef YCR1_DMEM_COPY_FILL_EN
    logic                  r_fill;
    assign w_fill       = r_fill;
    assign w_start_fill = cfg_fill;
    assign w_pattern    = cfg_pattern;
`else
    assign w_fill       = 1'b0;
    assign w_start_fill = 1'b0;
    assign w_pattern    = 32'h0;
`endif

    assign dmem_width = 2'b10;

    // A response arriving together with the ack ends the phase without visiting the RSP state.
    assign w_rsp_vld = (dmem_resp != RESP_NOTRDY);
    assign w_rsp_ok  = (dmem_resp == RESP_RDY_OK);
    assign w_rd_end  = w_rsp_vld && (((r_state == S_RD_REQ) && dmem_req_ack) || (r_state == S_RD_RSP));
    assign w_wr_end  = w_rsp_vld && (((r_state == S_WR_REQ) && dmem_req_ack) || (r_state == S_WR_RSP));
    assign w_last    = (r_rem == LEN_WIDTH'(1));
    assign w_src_nxt = r_src + 32'd4;
    assign w_dst_nxt = r_dst + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= 32'h0;
            r_dst      <= 32'h0;
            r_rem      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_cnt   <= '0;
            dmem_req   <= 1'b0;
            dmem_cmd   <= CMD_RD;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
`ifdef YCR1_DMEM_COPY_FILL_EN
            r_fill     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_src    <= {cfg_src[31:2], 2'b00};
                        r_dst    <= {cfg_dst[31:2], 2'b00};
                        r_rem    <= cfg_len;
                        err      <= 1'b0;
                        xfer_cnt <= '0;
`ifdef YCR1_DMEM_COPY_FILL_EN
                        r_fill   <= cfg_fill;
`endif
                        if (cfg_len == '0) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else if (w_start_fill) begin
                            r_state    <= S_WR_REQ;
                            busy       <= 1'b1;
                            dmem_req   <= 1'b1;
                            dmem_cmd   <= CMD_WR;
                            dmem_addr  <= {cfg_dst[31:2], 2'b00};
                            dmem_wdata <= w_pattern;
                        end else begin
                            r_state   <= S_RD_REQ;
                            busy      <= 1'b1;
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= CMD_RD;
                            dmem_addr <= {cfg_src[31:2], 2'b00};
                        end
                    end
                end
                S_RD_REQ, S_RD_RSP: begin
                    if (w_rd_end) begin
                        if (w_rsp_ok) begin
                            r_state    <= S_WR_REQ;
                            dmem_req   <= 1'b1;
                            dmem_cmd   <= CMD_WR;
                            dmem_addr  <= r_dst;
                            dmem_wdata <= dmem_rdata;
                        end else begin
                            r_state  <= S_FIN;
                            err      <= 1'b1;
                            dmem_req <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else if ((r_state == S_RD_REQ) && dmem_req_ack) begin
                        r_state  <= S_RD_RSP;
                        dmem_req <= 1'b0;
                    end
                end
                S_WR_REQ, S_WR_RSP: begin
                    if (w_wr_end) begin
                        if (w_rsp_ok) begin
                            xfer_cnt <= xfer_cnt + LEN_WIDTH'(1);
                            r_rem    <= r_rem - LEN_WIDTH'(1);
                            r_src    <= w_src_nxt;
                            r_dst    <= w_dst_nxt;
                            if (w_last) begin
                                r_state  <= S_FIN;
                                dmem_req <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else if (w_fill) begin
                                r_state   <= S_WR_REQ;
                                dmem_req  <= 1'b1;
                                dmem_cmd  <= CMD_WR;
                                dmem_addr <= w_dst_nxt;
                            end else begin
                                r_state   <= S_RD_REQ;
                                dmem_req  <= 1'b1;
                                dmem_cmd  <= CMD_RD;
                                dmem_addr <= w_src_nxt;
                            end
                        end else begin
                            r_state  <= S_FIN;
                            err      <= 1'b1;
                            dmem_req <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else if ((r_state == S_WR_REQ) && dmem_req_ack) begin
                        r_state  <= S_WR_RSP;
                        dmem_req <= 1'b0;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ycr1_dmem_copy.sv
// Randomized bench for ycr1_dmem_copy: memory responder, reference transfer model, scoreboard monitor.
module tb_ycr1_dmem_copy;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [31:0]   cfg_src;
    logic [31:0]   cfg_dst;
    logic [LW-1:0] cfg_len;
`ifdef YCR1_DMEM_COPY_FILL_EN
    logic          cfg_fill;
    logic [31:0]   cfg_pattern;
`endif
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] xfer_cnt;
    logic          dmem_req;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_req_ack;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;

    always #5 clk = ~clk;

    ycr1_dmem_copy #(.LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_src      (cfg_src),
        .cfg_dst      (cfg_dst),
        .cfg_len      (cfg_len),
`ifdef YCR1_DMEM_COPY_FILL_EN
        .cfg_fill     (cfg_fill),
        .cfg_pattern  (cfg_pattern),
`endif
        .busy         (busy),
        .done         (done),
        .err          (err),
        .xfer_cnt     (xfer_cnt),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    typedef struct packed {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct packed {
        logic          err;
        logic [LW-1:0] cnt;
    } fin_t;

    op_t         exp_ops[$];
    fin_t        exp_fin[$];
    logic [31:0] rmem[logic [31:0]];
    logic [31:0] mmem[logic [31:0]];
    int          n_chk = 0;
    int          n_pass = 0;
    int          resp_mode = 0;
    int          err_rd = -1;
    int          err_wr = -1;
    int          rd_seen = 0;
    int          wr_seen = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    function automatic logic [31:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mget(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : init_word(a);
    endfunction

    // mode 0 random, 1 ack+1/resp+1, 2 ack and resp in first req cycle, 3 ack after 4 cycles
    function automatic int pick_wait();
        case (resp_mode)
            1:       return 1;
            2:       return 0;
            3:       return 4;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    function automatic bit pick_same();
        case (resp_mode)
            1:       return 1'b0;
            2, 3:    return 1'b1;
            default: return ($urandom_range(0, 2) == 0);
        endcase
    endfunction

    function automatic int pick_lat();
        return (resp_mode == 1) ? 0 : int'($urandom_range(0, 3));
    endfunction

    task automatic respond(input op_t o);
        bit e;
        if (o.cmd == 1'b0) begin
            e = (rd_seen == err_rd);
            rd_seen++;
            dmem_rdata = e ? 32'hDEADBEEF : rget(o.addr);
        end else begin
            e = (wr_seen == err_wr);
            wr_seen++;
            if (!e) rmem[o.addr] = o.data;
            dmem_rdata = $urandom;
        end
        dmem_resp = e ? 2'b10 : 2'b01;
    endtask

    // Memory responder: drives ack/resp on the falling edge.
    initial begin
        int  wt;
        int  cnt;
        bit  outst;
        op_t cur;
        dmem_req_ack = 1'b0;
        dmem_resp    = 2'b00;
        dmem_rdata   = 32'h0;
        wt = -1; cnt = 0; outst = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            dmem_req_ack = 1'b0;
            dmem_resp    = 2'b00;
            if (rst) begin
                outst = 1'b0;
                wt    = -1;
                continue;
            end
            if (outst) begin
                if (cnt == 0) begin
                    respond(cur);
                    outst = 1'b0;
                end else cnt--;
            end else if (dmem_req) begin
                if (wt < 0) wt = pick_wait();
                if (wt == 0) begin
                    dmem_req_ack = 1'b1;
                    cur = '{dmem_cmd, dmem_addr, dmem_wdata};
                    wt  = -1;
                    if (pick_same()) respond(cur);
                    else begin
                        outst = 1'b1;
                        cnt   = pick_lat();
                    end
                end else wt--;
            end
        end
    end

    // Scoreboard monitor: accepted requests, held-request stability, done results.
    initial begin
        bit   hold;
        op_t  prev;
        op_t  e;
        fin_t f;
        hold = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                chk("req_held", {95'h0, dmem_req}, 96'h1);
                chk("req_fields_stable", {31'h0, dmem_cmd, dmem_addr, dmem_wdata}, {31'h0, prev});
            end
            if (dmem_req && dmem_req_ack) begin
                hold = 1'b0;
                if (exp_ops.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_bus_op: got cmd %0d addr %0h, expected no request", dmem_cmd, dmem_addr);
                end else begin
                    e = exp_ops.pop_front();
                    chk("op_cmd", {95'h0, dmem_cmd}, {95'h0, e.cmd});
                    chk("op_addr", {64'h0, dmem_addr}, {64'h0, e.addr});
                    if (e.cmd) chk("op_wdata", {64'h0, dmem_wdata}, {64'h0, e.data});
                    chk("op_width", {94'h0, dmem_width}, 96'h2);
                end
            end else if (dmem_req) begin
                hold = 1'b1;
                prev = '{dmem_cmd, dmem_addr, dmem_wdata};
            end else hold = 1'b0;
            if (done) begin
                if (exp_fin.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    f = exp_fin.pop_front();
                    chk("err_at_done", {95'h0, err}, {95'h0, f.err});
                    chk("xfer_cnt_at_done", {80'h0, xfer_cnt}, {80'h0, f.cnt});
                    chk("busy_low_at_done", {95'h0, busy}, 96'h0);
                end
            end
        end
    end

    // Reference model: sequential word-by-word semantics over a shadow memory.
    task automatic issue(input logic [31:0] src, input logic [31:0] dst, input int len,
                         input bit fill, input logic [31:0] pat, input int erd, input int ewr);
        logic [31:0] as;
        logic [31:0] ad;
        logic [31:0] d;
        int          cnt;
        bit          e;
        as = {src[31:2], 2'b00};
        ad = {dst[31:2], 2'b00};
        cnt = 0; e = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (!fill) begin
                exp_ops.push_back('{1'b0, as, 32'h0});
                if (i == erd) begin e = 1'b1; break; end
                d = mget(as);
            end else d = pat;
            exp_ops.push_back('{1'b1, ad, d});
            if (i == ewr) begin e = 1'b1; break; end
            mmem[ad] = d;
            cnt++;
            as += 32'd4;
            ad += 32'd4;
        end
        exp_fin.push_back('{e, LW'(cnt)});
        err_rd = erd; err_wr = ewr; rd_seen = 0; wr_seen = 0;
        @(negedge clk);
        cfg_src = src; cfg_dst = dst; cfg_len = LW'(len);
`ifdef YCR1_DMEM_COPY_FILL_EN
        cfg_fill = fill; cfg_pattern = pat;
`endif
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        if (len > 0) begin
            chk("busy_rise", {95'h0, busy}, 96'h1);
            chk("req_rise", {95'h0, dmem_req}, 96'h1);
        end
    endtask

    task automatic xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                        input bit fill, input logic [31:0] pat, input int erd, input int ewr,
                        output int cyc);
        issue(src, dst, len, fill, pat, erd, ewr);
        cyc = 1;
        while (!done && cyc < 1000) begin
            if (cyc == 3 && busy) begin
                cfg_start = 1'b1; cfg_src = $urandom; cfg_dst = $urandom; cfg_len = 1;
            end else cfg_start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        cfg_start = 1'b0;
        if (!done) chk("done_timeout", 96'h0, 96'h1);
        @(negedge clk);
        chk("ops_drained", 96'(exp_ops.size()), 96'h0);
    endtask

    initial begin
        int cyc;
        int len;
        int erd;
        int ewr;
        logic [31:0] src;
        logic [31:0] dst;
        rst = 1'b1; cfg_start = 1'b0; cfg_src = 32'h0; cfg_dst = 32'h0; cfg_len = '0;
`ifdef YCR1_DMEM_COPY_FILL_EN
        cfg_fill = 1'b0; cfg_pattern = 32'h0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", {95'h0, busy}, 96'h0);
        chk("rst_done", {95'h0, done}, 96'h0);
        chk("rst_err", {95'h0, err}, 96'h0);
        chk("rst_xfer_cnt", {80'h0, xfer_cnt}, 96'h0);
        chk("rst_req", {95'h0, dmem_req}, 96'h0);
        chk("rst_width", {94'h0, dmem_width}, 96'h2);
        chk("rst_addr", {64'h0, dmem_addr}, 96'h0);
        chk("rst_wdata", {64'h0, dmem_wdata}, 96'h0);
        rst = 1'b0;
        @(negedge clk);

        // timer-style copy, ack +1 / resp +1: 6 cycles per word
        resp_mode = 1;
        xfer(32'h08, 32'h10, 2, 1'b0, 32'h0, -1, -1, cyc);
        chk("timing_6_per_word", 96'(cyc), 96'd13);
        xfer(32'h40, 32'h80, 0, 1'b0, 32'h0, -1, -1, cyc);
        chk("len0_done_latency", 96'(cyc), 96'd1);
        resp_mode = 0;
        xfer(32'h200, 32'h300, 5, 1'b0, 32'h0, 2, -1, cyc);
        xfer(32'h400, 32'h500, 4, 1'b0, 32'h0, -1, 1, cyc);
        resp_mode = 2;
        xfer(32'h600, 32'h700, 3, 1'b0, 32'h0, -1, -1, cyc);
        chk("same_cycle_ack_resp_timing", 96'(cyc), 96'd7);
        resp_mode = 3;
        xfer(32'h803, 32'h901, 2, 1'b0, 32'h0, -1, -1, cyc);
        resp_mode = 0;
        xfer(32'h1000, 32'hFFFF_FFFC, 2, 1'b0, 32'h0, -1, -1, cyc);
        chk("wrap_word_written", {64'h0, rget(32'h0)}, {64'h0, init_word(32'h1004)});

        for (int t = 0; t < 24; t++) begin
            len = int'($urandom_range(0, 6));
            src = $urandom;
            dst = ($urandom_range(0, 3) == 0) ? src + 32'd4 : $urandom;
            erd = -1; ewr = -1;
            case ($urandom_range(0, 7))
                0: erd = int'($urandom_range(0, 6));
                1: ewr = int'($urandom_range(0, 6));
                default: ;
            endcase
            xfer(src, dst, len, 1'b0, 32'h0, erd, ewr, cyc);
        end

`ifdef YCR1_DMEM_COPY_FILL_EN
        xfer($urandom, 32'h100, 3, 1'b1, 32'hA5A5_A5A5, -1, -1, cyc);
        chk("fill_last_word", {64'h0, rget(32'h108)}, {64'h0, 32'hA5A5_A5A5});
`endif

        // reset in the middle of a transfer
        issue(32'h2000, 32'h3000, 8, 1'b0, 32'h0, -1, -1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {95'h0, busy}, 96'h0);
        chk("midrst_done", {95'h0, done}, 96'h0);
        chk("midrst_err", {95'h0, err}, 96'h0);
        chk("midrst_xfer_cnt", {80'h0, xfer_cnt}, 96'h0);
        chk("midrst_req", {95'h0, dmem_req}, 96'h0);
        chk("midrst_cmd", {95'h0, dmem_cmd}, 96'h0);
        chk("midrst_width", {94'h0, dmem_width}, 96'h2);
        chk("midrst_addr", {64'h0, dmem_addr}, 96'h0);
        chk("midrst_wdata", {64'h0, dmem_wdata}, 96'h0);
        exp_ops.delete();
        exp_fin.delete();
        @(negedge clk);
        rst = 1'b0;
        mmem = rmem;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_rst", {95'h0, done}, 96'h0);
        end
        xfer(32'h2000, 32'h3000, 3, 1'b0, 32'h0, -1, -1, cyc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
